// File: rtl/sipo_y_ctrl_pkg.sv
// Shared types and defaults for the Y-operand SRL ring sequencer.
package sipo_y_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int PE_NUM_DEF     = 8;
  localparam int REG_NUM_DEF    = 32;
  localparam int ITER_NUM_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Never returns zero, so a modulus of 1 still gets a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sipo_y_ctrl_cnt.sv
// Modulo-N counter with enable, synchronous clear and terminal-count flag.
module sipo_y_ctrl_cnt #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_y_ctrl.sv
// Sequencer for the Y-operand SRL ring: load phase from a stream, then ITER_NUM shift rounds.
// Optional abort port pair is enabled by defining SIPO_Y_CTRL_ABORT_EN.
module sipo_y_ctrl
  import sipo_y_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PE_NUM     = PE_NUM_DEF,
  parameter int REG_NUM    = REG_NUM_DEF,
  parameter int ITER_NUM   = ITER_NUM_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  input  logic [2*DATA_WIDTH-1:0] srl_tail,
  output logic                    srl_ce,
  output logic [2*DATA_WIDTH-1:0] srl_din,
  input  logic                    pe_ready,
  output logic                    round_start,
  output logic                    p_out_v,
  output logic                    busy,
  output logic                    done
`ifdef SIPO_Y_CTRL_ABORT_EN
  ,
  input  logic                    abort,
  output logic                    abort_ack
`endif
);

  localparam int LOAD_N = PE_NUM * REG_NUM;

  state_t state, state_nx;

  logic beat;
  logic abort_hit;
  logic load_tc, shift_tc, iter_tc;
  logic shift_en, iter_en, cnt_clr;
  logic ce_shift_q;

`ifdef SIPO_Y_CTRL_ABORT_EN
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign beat     = s_valid && s_ready;
  assign shift_en = (state == ST_SHIFT) && !abort_hit;
  assign iter_en  = shift_en && shift_tc;
  assign cnt_clr  = abort_hit || (state == ST_IDLE);

  sipo_y_ctrl_cnt #(.N(LOAD_N), .W(cnt_width(LOAD_N))) u_load_cnt (
    .clk (clk),
    .rst (rst),
    .en  (beat),
    .clr (cnt_clr),
    .tc  (load_tc)
  );

  sipo_y_ctrl_cnt #(.N(REG_NUM), .W(cnt_width(REG_NUM))) u_shift_cnt (
    .clk (clk),
    .rst (rst),
    .en  (shift_en),
    .clr (cnt_clr),
    .tc  (shift_tc)
  );

  sipo_y_ctrl_cnt #(.N(ITER_NUM), .W(cnt_width(ITER_NUM))) u_iter_cnt (
    .clk (clk),
    .rst (rst),
    .en  (iter_en),
    .clr (cnt_clr),
    .tc  (iter_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    s_ready     = 1'b0;
    round_start = 1'b0;
    busy        = (state != ST_IDLE);
    done        = 1'b0;
    if (abort_hit) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nx = ST_LOAD;
        end
        ST_LOAD: begin
          s_ready = 1'b1;
          if (s_valid && load_tc) state_nx = ST_WAIT;
        end
        ST_WAIT: begin
          if (pe_ready) begin
            state_nx    = ST_SHIFT;
            round_start = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shift_tc) state_nx = iter_tc ? ST_DONE : ST_WAIT;
        end
        ST_DONE: begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Ring controls lag the decision by one cycle; p_out_v lags shift-driven enables by one more.
  always_ff @(posedge clk) begin
    if (rst) begin
      srl_ce     <= 1'b0;
      srl_din    <= '0;
      ce_shift_q <= 1'b0;
      p_out_v    <= 1'b0;
    end else begin
      srl_ce     <= 1'b0;
      ce_shift_q <= 1'b0;
      p_out_v    <= ce_shift_q && !abort_hit;
      if (!abort_hit) begin
        if (beat) begin
          srl_ce  <= 1'b1;
          srl_din <= s_data;
        end else if (state == ST_SHIFT) begin
          srl_ce     <= 1'b1;
          srl_din    <= srl_tail;
          ce_shift_q <= 1'b1;
        end
      end
    end
  end

`ifdef SIPO_Y_CTRL_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_ack <= 1'b0;
    end else begin
      abort_ack <= abort_hit;
    end
  end
`endif

endmodule

// File: tb/tb_sipo_y_ctrl.sv
// Directed self-checking bench for sipo_y_ctrl (PE_NUM=4, REG_NUM=4, ITER_NUM=2).
module tb_sipo_y_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] srl_tail;
  logic        srl_ce;
  logic [31:0] srl_din;
  logic        pe_ready;
  logic        round_start;
  logic        p_out_v;
  logic        busy;
  logic        done;
`ifdef SIPO_Y_CTRL_ABORT_EN
  logic        abort;
  logic        abort_ack;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  sipo_y_ctrl #(
    .DATA_WIDTH (16),
    .PE_NUM     (4),
    .REG_NUM    (4),
    .ITER_NUM   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .srl_tail    (srl_tail),
    .srl_ce      (srl_ce),
    .srl_din     (srl_din),
    .pe_ready    (pe_ready),
    .round_start (round_start),
    .p_out_v     (p_out_v),
    .busy        (busy),
    .done        (done)
`ifdef SIPO_Y_CTRL_ABORT_EN
    ,
    .abort       (abort),
    .abort_ack   (abort_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_s_ready"}, s_ready, 1'b0);
    check_bit({tag, "_srl_ce"}, srl_ce, 1'b0);
    check_word({tag, "_srl_din"}, srl_din, 32'h0);
    check_bit({tag, "_round_start"}, round_start, 1'b0);
    check_bit({tag, "_p_out_v"}, p_out_v, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
  endtask

  // Entered with the DUT in LOAD; 16 back-to-back beats.
  task automatic load_burst(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      step();
      check_bit("burst_ce", srl_ce, 1'b1);
      check_word("burst_din", srl_din, base + 32'(i));
      check_bit("burst_ready", s_ready, i < 15);
    end
    s_valid = 1'b0;
    step();
    check_bit("burst_ce_after", srl_ce, 1'b0);
    check_bit("burst_wait_busy", busy, 1'b1);
  endtask

  // Entered with the DUT in WAIT.
  task automatic run_round(input int r, input logic last);
    logic [31:0] base;
    int          done_cnt;
    base     = 32'hA000 + 32'(r * 256);
    done_cnt = 0;
    pe_ready = 1'b1;
    #1;
    check_bit("round_start_pulse", round_start, 1'b1);
    step();
    pe_ready = 1'b0;
    check_bit("round_start_drop", round_start, 1'b0);
    for (int k = 0; k < 6; k++) begin
      srl_tail = base + 32'(k);
      start    = last && (k == 1 || k == 4);
      step();
      check_bit("shift_ce", srl_ce, k < 4);
      if (k < 4) check_word("shift_din", srl_din, base + 32'(k));
      check_bit("shift_pov", p_out_v, (k >= 1) && (k <= 4));
      check_bit("shift_round_start", round_start, 1'b0);
      if (done) done_cnt++;
      if (k == 3) check_bit("round_end_done", done, last);
      if (k >= 4) check_bit("round_end_busy", busy, !last);
    end
    start = 1'b0;
    check_word("done_count", 32'(done_cnt), last ? 32'd1 : 32'd0);
    if (last) check_bit("idle_no_restart", s_ready, 1'b0);
  endtask

  initial begin
    int ce_cnt;
    int nb;
    logic v;

    rst      = 1'b1;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    srl_tail = '0;
    pe_ready = 1'b0;
`ifdef SIPO_Y_CTRL_ABORT_EN
    abort    = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    // Job 1: start with s_valid high must not take a beat in IDLE.
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    step();
    start = 1'b0;
    check_bit("start_no_beat", srl_ce, 1'b0);
    check_bit("load_ready", s_ready, 1'b1);
    check_bit("load_busy", busy, 1'b1);
    load_burst(32'h0);

    // Hold in WAIT; start while busy is ignored.
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_bit("wait_ce", srl_ce, 1'b0);
      check_bit("wait_rs", round_start, 1'b0);
      check_bit("wait_ready", s_ready, 1'b0);
    end
    start = 1'b0;
    run_round(0, 1'b0);
    run_round(1, 1'b1);

    // Job 2: s_valid toggled during load.
    start = 1'b1;
    step();
    start  = 1'b0;
    ce_cnt = 0;
    nb     = 0;
    for (int j = 0; j < 32; j++) begin
      v       = (j % 2 == 0);
      s_valid = v;
      s_data  = 32'h100 + 32'(nb);
      step();
      check_bit("toggle_ce", srl_ce, v);
      if (srl_ce) begin
        check_word("toggle_din", srl_din, 32'h100 + 32'(nb));
        ce_cnt++;
      end
      if (v) nb++;
      check_bit("toggle_ready", s_ready, nb < 16);
    end
    s_valid = 1'b0;
    check_word("toggle_loads", 32'(ce_cnt), 32'd16);
    run_round(0, 1'b0);
    run_round(1, 1'b1);

    // Job 3: reset at load beat 7, then reload from count 0.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h200 + 32'(i);
      step();
    end
    s_data = 32'h207;
    rst    = 1'b1;
    step();
    rst     = 1'b0;
    s_valid = 1'b0;
    check_all_zero("mid_reset");
    start = 1'b1;
    step();
    start = 1'b0;
    load_burst(32'h300);

`ifdef SIPO_Y_CTRL_ABORT_EN
    pe_ready = 1'b1;
    step();
    pe_ready = 1'b0;
    srl_tail = 32'hB000;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_bit("abort_ack", abort_ack, 1'b1);
    check_bit("abort_done", done, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_ce", srl_ce, 1'b0);
    step();
    check_bit("abort_ack_drop", abort_ack, 1'b0);
    check_bit("abort_pov", p_out_v, 1'b0);
    check_bit("abort_done2", done, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
